// File: rtl/rv32v_mem_lane_sequencer.sv
// rtl/rv32v_mem_lane_sequencer.sv - serialises a two-lane vector load/store beat onto one memory port
module rv32v_mem_lane_sequencer #(
    parameter int OFF_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_ena,
    input  logic             store_ena,
    input  logic [1:0]       wen,
    input  logic [31:0]      aluresult0,
    input  logic [31:0]      aluresult1,
    input  logic [31:0]      storedata0,
    input  logic [31:0]      storedata1,
    input  logic [1:0]       eew,
    input  logic [OFF_W-1:0] woffset0,
    input  logic [OFF_W-1:0] woffset1,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_en,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata0,
    output logic [31:0]      rdata1,
    output logic [1:0]       wen_out,
    output logic [OFF_W-1:0] woffset0_out,
    output logic [OFF_W-1:0] woffset1_out,
    output logic [1:0]       err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

    state_t           state, state_nxt;
    logic             is_load;
    logic [1:0]       wen_q, eew_q;
    logic [31:0]      addr0_q, addr1_q, data0_q, data1_q;
    logic [CNT_W-1:0] wait_cnt;

    logic        start, lane_active, lane_idx, misaligned, req, timed_out, lane_end;
    logic [31:0] lane_addr, lane_data, rdata_shift, load_val, wdata_rep;
    logic [3:0]  be;

    assign start = (state == IDLE) && (load_ena || store_ena) && (wen != 2'b00);

    always_comb begin
        lane_active = (state == LANE0) || (state == LANE1);
        lane_idx    = (state == LANE1);
        lane_addr   = lane_idx ? addr1_q : addr0_q;
        lane_data   = lane_idx ? data1_q : data0_q;
        rdata_shift = mem_rdata >> {lane_addr[1:0], 3'b000};
        case (eew_q)
            2'b00: begin
                misaligned = 1'b0;
                be         = 4'b0001 << lane_addr[1:0];
                wdata_rep  = {4{lane_data[7:0]}};
                load_val   = {24'd0, rdata_shift[7:0]};
            end
            2'b01: begin
                misaligned = lane_addr[0];
                be         = 4'b0011 << {lane_addr[1], 1'b0};
                wdata_rep  = {2{lane_data[15:0]}};
                load_val   = {16'd0, rdata_shift[15:0]};
            end
            default: begin
                misaligned = |lane_addr[1:0];
                be         = 4'b1111;
                wdata_rep  = lane_data;
                load_val   = mem_rdata;
            end
        endcase
        req       = lane_active && !misaligned;
        // The abort fires in the last allowed wait cycle, so the request is seen for exactly TIMEOUT cycles
        timed_out = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1) && !mem_ack;
        lane_end  = lane_active && (misaligned || mem_ack || timed_out);

        mem_ren     = req && is_load && !mem_ack;
        mem_wen     = req && !is_load && !mem_ack;
        mem_addr    = req ? {lane_addr[31:2], 2'b00} : 32'd0;
        mem_byte_en = req ? be : 4'd0;
        mem_wdata   = (req && !is_load) ? wdata_rep : 32'd0;
        busy        = (state != IDLE);
        done        = (state == DONE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = wen[0] ? LANE0 : LANE1;
            LANE0:   if (lane_end) state_nxt = wen_q[1] ? LANE1 : DONE;
            LANE1:   if (lane_end) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            is_load      <= 1'b0;
            wen_q        <= 2'b00;
            eew_q        <= 2'b00;
            addr0_q      <= 32'd0;
            addr1_q      <= 32'd0;
            data0_q      <= 32'd0;
            data1_q      <= 32'd0;
            wait_cnt     <= '0;
            rdata0       <= 32'd0;
            rdata1       <= 32'd0;
            wen_out      <= 2'b00;
            woffset0_out <= '0;
            woffset1_out <= '0;
            err          <= 2'b00;
        end else begin
            state <= state_nxt;
            if (start) begin
                is_load      <= load_ena;
                wen_q        <= wen;
                eew_q        <= eew;
                addr0_q      <= aluresult0;
                addr1_q      <= aluresult1;
                data0_q      <= storedata0;
                data1_q      <= storedata1;
                rdata0       <= 32'd0;
                rdata1       <= 32'd0;
                wen_out      <= wen;
                woffset0_out <= woffset0;
                woffset1_out <= woffset1;
                err          <= 2'b00;
            end
            if (misaligned && lane_active || req && timed_out)
                err[lane_idx] <= 1'b1;
            if (req && mem_ack && is_load) begin
                if (lane_idx) rdata1 <= load_val;
                else          rdata0 <= load_val;
            end
            if (!lane_active || lane_end) wait_cnt <= '0;
            else                          wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
endmodule
